num_entry: RTL and testbench

NUM_ENTRY -- requirements
Module: num_entry

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/key_edge.sv | 29 ++
 rtl/num_entry.sv | 126 ++++++++++++
 tb/tb_num_entry.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, key classification and FSM state type for the keypad
// number-entry block.
package keypad_pkg;

    localparam int unsigned NDIGITS_DEF = 3;
    localparam int unsigned VAL_W_DEF   = 10;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KC_DIGIT = 2'd0,
        KC_STAR  = 2'd1,
        KC_HASH  = 2'd2,
        KC_OTHER = 2'd3
    } key_class_e;

    function automatic key_class_e classify_key(input logic [3:0] code);
        key_class_e kc;
        if (code <= 4'd9) begin
            kc = KC_DIGIT;
        end else if (code == KEY_STAR) begin
            kc = KC_STAR;
        end else if (code == KEY_HASH) begin
            kc = KC_HASH;
        end else begin
            kc = KC_OTHER;
        end
        return kc;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector; the history flop resets to RESET_VAL so a
// level held across reset release is not mistaken for a new edge.
module key_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/num_entry.sv
// Keypad operand entry: accumulates up to NDIGITS decimal digits as BCD and as
// a binary value, commits on '#', clears on '*'.
module num_entry
    import keypad_pkg::*;
#(
    parameter int unsigned NDIGITS = NDIGITS_DEF,
    parameter int unsigned VAL_W   = VAL_W_DEF
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic [3:0]                     key_code,
    input  logic                           key_valid,
    output logic [4*NDIGITS-1:0]           digits,
    output logic [NDIGITS-1:0]             digit_en,
    output logic [$clog2(NDIGITS+1)-1:0]   count,
    output logic [VAL_W-1:0]               value,
    output logic                           value_valid,
    output logic                           overflow
);

    localparam int unsigned CNT_W = $clog2(NDIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NDIGITS);

    logic key_event;

    key_edge #(
        .RESET_VAL(1'b1)
    ) u_key_edge (
        .clk    (clk),
        .n_reset(n_reset),
        .level  (key_valid),
        .rise   (key_event)
    );

    state_e                 state_q, state_d;
    logic [4*NDIGITS-1:0]   digits_q, digits_d;
    logic [NDIGITS-1:0]     digit_en_q, digit_en_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [VAL_W-1:0]       value_q, value_d;
    logic                   value_valid_q, value_valid_d;
    logic                   overflow_q, overflow_d;

    always_comb begin
        state_d       = state_q;
        digits_d      = digits_q;
        count_d       = count_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        overflow_d    = 1'b0;

        if (key_event) begin
            unique case (classify_key(key_code))
                KC_DIGIT: begin
                    if (state_q == S_DONE) begin
                        // A new digit after commit starts a fresh operand.
                        digits_d      = '0;
                        digits_d[3:0] = key_code;
                        count_d       = CNT_W'(1);
                        value_d       = VAL_W'(key_code);
                        state_d       = S_ENTRY;
                    end else if (count_q < MAX_CNT) begin
                        digits_d      = digits_q << 4;
                        digits_d[3:0] = key_code;
                        count_d       = count_q + CNT_W'(1);
                        value_d       = value_q * VAL_W'(10) + VAL_W'(key_code);
                        state_d       = S_ENTRY;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                KC_STAR: begin
                    digits_d = '0;
                    count_d  = '0;
                    value_d  = '0;
                    state_d  = S_EMPTY;
                end
                KC_HASH: begin
                    if (state_q == S_ENTRY) begin
                        value_valid_d = 1'b1;
                        state_d       = S_DONE;
                    end
                end
                KC_OTHER: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Display enables follow the next count so they stay aligned with digits.
    always_comb begin
        digit_en_d = '0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            digit_en_d[i] = (CNT_W'(i) < count_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= S_EMPTY;
            digits_q      <= '0;
            digit_en_q    <= '0;
            count_q       <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            digits_q      <= digits_d;
            digit_en_q    <= digit_en_d;
            count_q       <= count_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign digits      = digits_q;
    assign digit_en    = digit_en_q;
    assign count       = count_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_num_entry.sv
// Bench for num_entry: stimulus pushes predicted outputs into a queue, a
// monitor pops and compares one snapshot per clock.
module tb_num_entry;

    localparam int ND = 3;
    localparam int VW = 10;

    logic              clk = 1'b0;
    logic              n_reset;
    logic [3:0]        key_code;
    logic              key_valid;
    logic [4*ND-1:0]   digits;
    logic [ND-1:0]     digit_en;
    logic [1:0]        count;
    logic [VW-1:0]     value;
    logic              value_valid;
    logic              overflow;

    num_entry #(
        .NDIGITS(ND),
        .VAL_W  (VW)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .digits     (digits),
        .digit_en   (digit_en),
        .count      (count),
        .value      (value),
        .value_valid(value_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*ND-1:0] digits;
        logic [ND-1:0]   en;
        logic [1:0]      count;
        logic [VW-1:0]   value;
        logic            vv;
        logic            ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the operand as a list of entered digits.
    int ent[$];
    bit m_done = 0;
    bit m_prev = 1;

    task automatic model_step(input logic rst_n, input logic kv, input logic [3:0] kc);
        exp_t e;
        int   v;
        bit   ev;
        e.vv = 1'b0;
        e.ov = 1'b0;
        if (!rst_n) begin
            ent.delete();
            m_done = 0;
            m_prev = 1;
        end else begin
            ev = kv && !m_prev;
            m_prev = kv;
            if (ev) begin
                if (kc <= 4'd9) begin
                    if (m_done) begin
                        ent.delete();
                        ent.push_back(int'(kc));
                        m_done = 0;
                    end else if (ent.size() < ND) begin
                        ent.push_back(int'(kc));
                    end else begin
                        e.ov = 1'b1;
                    end
                end else if (kc == 4'hE) begin
                    ent.delete();
                    m_done = 0;
                end else if (kc == 4'hF) begin
                    if (ent.size() > 0 && !m_done) begin
                        e.vv   = 1'b1;
                        m_done = 1;
                    end
                end
            end
        end
        v = 0;
        e.digits = '0;
        for (int i = 0; i < ent.size(); i++) begin
            v = v * 10 + ent[i];
            e.digits[4*(ent.size()-1-i) +: 4] = 4'(ent[i]);
        end
        e.value = VW'(v);
        e.count = 2'(ent.size());
        e.en    = ND'((1 << ent.size()) - 1);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic rst_n, input logic kv, input logic [3:0] kc);
        @(negedge clk);
        n_reset   = rst_n;
        key_valid = kv;
        key_code  = kc;
        model_step(rst_n, kv, kc);
    endtask

    task automatic press(input logic [3:0] kc, input int hold, input int gap);
        repeat (hold) cycle(1'b1, 1'b1, kc);
        repeat (gap) cycle(1'b1, 1'b0, kc);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("digits", 32'(digits), 32'(e.digits));
                check("digit_en", 32'(digit_en), 32'(e.en));
                check("count", 32'(count), 32'(e.count));
                check("value", 32'(value), 32'(e.value));
                check("value_valid", 32'(value_valid), 32'(e.vv));
                check("overflow", 32'(overflow), 32'(e.ov));
                check("pulse_exclusive", 32'(value_valid & overflow), 32'(0));
            end
        end
    end

    initial begin : stimulus
        int r;
        int wait_cnt;
        logic [3:0] kc;
        n_reset   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);

        // 1,2,3 then commit
        press(4'd1, 2, 2);
        press(4'd2, 1, 1);
        press(4'd3, 3, 2);
        press(4'hF, 2, 2);
        // new digit after commit, then clear
        press(4'd5, 1, 2);
        press(4'hE, 1, 2);
        // overflow on fourth digit
        press(4'd4, 1, 1);
        press(4'd5, 1, 1);
        press(4'd6, 1, 1);
        press(4'd7, 2, 2);
        press(4'hE, 1, 1);
        // long hold produces a single entry
        press(4'd9, 20, 2);
        press(4'd8, 1, 2);
        press(4'hE, 1, 1);
        // '#' while empty, 'B' while entering
        press(4'hF, 1, 2);
        press(4'd3, 1, 1);
        press(4'hB, 2, 2);
        press(4'hE, 1, 1);
        // leading zeros count as digits
        press(4'd0, 1, 1);
        press(4'd0, 1, 1);
        press(4'd7, 1, 1);
        press(4'hF, 1, 1);
        press(4'hF, 1, 1);
        // reset mid-entry with a key held across release
        press(4'd4, 1, 1);
        press(4'd2, 1, 1);
        cycle(1'b1, 1'b1, 4'd7);
        repeat (3) cycle(1'b0, 1'b1, 4'd7);
        repeat (5) cycle(1'b1, 1'b1, 4'd7);
        press(4'd7, 0, 2);
        press(4'd7, 1, 2);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) kc = 4'($urandom_range(0, 9));
            else if (r < 72) kc = 4'hF;
            else if (r < 82) kc = 4'hE;
            else kc = 4'($urandom_range(10, 13));
            if ($urandom_range(0, 99) < 2) begin
                repeat (int'($urandom_range(1, 3)))
                    cycle(1'b0, 1'($urandom_range(0, 1)), kc);
            end
            press(kc, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        n_tests++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
